// File: rtl/instruction_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_mem_arbiter_pkg
// Description : Shared GPU types for the instruction-memory path and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_mem_arbiter_pkg;

    typedef logic [15:0] instruction_t;
    typedef logic [7:0]  instruction_memory_address_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : instruction_mem_arbiter_rr_picker
// Description : Combinational round-robin picker. Returns the first asserted
//               request at index i_ptr, i_ptr+1, ... (mod W).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_mem_arbiter_rr_picker #(
    parameter int W     = 4,
    parameter int PTR_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_any,
    output logic [PTR_W-1:0] o_idx
);

    always_comb begin
        int w_cand;
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        // Scan farthest offset first so the nearest requester at/after i_ptr wins.
        for (int off = W - 1; off >= 0; off--) begin
            w_cand = int'(i_ptr) + off;
            if (w_cand >= W) begin
                w_cand = w_cand - W;
            end
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = PTR_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : instruction_mem_arbiter
// Description : Round-robin arbiter sharing one instruction-memory read
//               channel among per-warp fetchers; one outstanding read.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_mem_arbiter
    import instruction_mem_arbiter_pkg::*;
#(
    parameter int WARPS_PER_CORE = 4
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [WARPS_PER_CORE-1:0]                        warp_read_valid,
    input  instruction_memory_address_t [WARPS_PER_CORE-1:0] warp_read_address,
    output logic [WARPS_PER_CORE-1:0]                        warp_read_ready,
    output instruction_t [WARPS_PER_CORE-1:0]                warp_read_data,
    output logic                                             mem_read_valid,
    output instruction_memory_address_t                      mem_read_address,
    input  logic                                             mem_read_ready,
    input  instruction_t                                     mem_read_data
);

    localparam int PTR_W = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1;
    localparam logic [PTR_W-1:0] C_LAST_WARP = PTR_W'(WARPS_PER_CORE - 1);

    arb_state_t                               r_state;
    arb_state_t                               w_state_next;
    logic [PTR_W-1:0]                         r_grant;
    logic [PTR_W-1:0]                         r_rr_ptr;
    logic                                     w_pick_any;
    logic [PTR_W-1:0]                         w_pick_idx;
    logic [WARPS_PER_CORE-1:0]                r_ready;
    instruction_t [WARPS_PER_CORE-1:0]        r_data;
    logic                                     r_mem_valid;
    instruction_memory_address_t              r_mem_addr;

    instruction_mem_arbiter_rr_picker #(
        .W     (WARPS_PER_CORE),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .i_req (warp_read_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any)     w_state_next = BUSY;
            BUSY:    if (mem_read_ready) w_state_next = RESPOND;
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers; mem_read_ready only matters in BUSY, so a stray
    // pulse after reset or between transactions is dropped here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_ready     <= '0;
            r_data      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant     <= w_pick_idx;
                        r_mem_addr  <= warp_read_address[w_pick_idx];
                        r_mem_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_read_ready) begin
                        r_mem_valid      <= 1'b0;
                        r_data[r_grant]  <= mem_read_data;
                        r_ready[r_grant] <= 1'b1;
                        r_rr_ptr         <= (r_grant == C_LAST_WARP) ? '0 : r_grant + 1'b1;
                    end
                end
                RESPOND: begin
                    r_ready <= '0;
                end
                default: begin
                    r_ready <= '0;
                end
            endcase
        end
    end

    assign warp_read_ready  = r_ready;
    assign warp_read_data   = r_data;
    assign mem_read_valid   = r_mem_valid;
    assign mem_read_address = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_mem_arbiter
// Description : Randomized scoreboard bench for instruction_mem_arbiter (W=4
//               and W=1 instances) with a queue-based fairness model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instruction_mem_arbiter;
    import instruction_mem_arbiter_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    // W=4 instance signals
    logic [W-1:0]                        valid = '0;
    instruction_memory_address_t [W-1:0] addr = '0;
    logic [W-1:0]                        ready;
    instruction_t [W-1:0]                rdata;
    logic                                mvalid;
    instruction_memory_address_t         maddr;
    logic                                mready = 1'b0;
    instruction_t                        mdata = '0;

    // W=1 instance signals
    logic [0:0]                          v1 = '0;
    instruction_memory_address_t [0:0]   a1 = '0;
    logic [0:0]                          r1;
    instruction_t [0:0]                  d1;
    logic                                mv1;
    instruction_memory_address_t         ma1;
    logic                                mr1 = 1'b0;
    instruction_t                        md1 = '0;

    instruction_mem_arbiter #(.WARPS_PER_CORE(W)) u_dut (
        .clk               (clk),
        .reset             (rst),
        .warp_read_valid   (valid),
        .warp_read_address (addr),
        .warp_read_ready   (ready),
        .warp_read_data    (rdata),
        .mem_read_valid    (mvalid),
        .mem_read_address  (maddr),
        .mem_read_ready    (mready),
        .mem_read_data     (mdata)
    );

    instruction_mem_arbiter #(.WARPS_PER_CORE(1)) u_dut_w1 (
        .clk               (clk),
        .reset             (rst1),
        .warp_read_valid   (v1),
        .warp_read_address (a1),
        .warp_read_ready   (r1),
        .warp_read_data    (d1),
        .mem_read_valid    (mv1),
        .mem_read_address  (ma1),
        .mem_read_ready    (mr1),
        .mem_read_data     (md1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           warp;
        instruction_t data;
    } exp_t;

    exp_t         sb[$];
    instruction_t sb1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state (W=4) ----------------
    logic [W-1:0] pending = '0;     // fetcher holds a request awaiting its pulse
    int           m_ptr = 0;        // warp with highest priority next round
    bit           inflight = 0;
    bit           resp_driven = 0;
    int           in_warp = 0;
    instruction_memory_address_t in_addr = '0;
    int           stall = 0;
    logic         prev_mvalid = 1'b0;
    int           cyc = 0;
    int           last_rise = -1;
    bit           done1 = 0;

    function automatic instruction_memory_address_t band_addr(input int w);
        return instruction_memory_address_t'(w * 64 + $urandom_range(0, 63));
    endfunction

    // One cycle of fetchers + memory, acting 1ns after the rising edge.
    task automatic step(input logic [W-1:0] mask, input int pct, input int smin,
                        input int smax, input bit chaos, input bit per_chk);
        logic [W-1:0]                        v_snap;
        instruction_memory_address_t [W-1:0] a_snap;
        int win;
        int c;
        @(posedge clk);
        #1;
        cyc++;
        v_snap = valid;
        a_snap = addr;
        mready = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (ready[i]) begin
                pending[i] = 1'b0;
                valid[i]   = 1'b0;
            end
        end
        if (resp_driven) begin
            inflight    = 0;
            resp_driven = 0;
        end
        if (mvalid && !prev_mvalid) begin
            win = -1;
            for (int k = 0; k < W; k++) begin
                c = (m_ptr + k) % W;
                if (win < 0 && v_snap[c]) win = c;
            end
            if (win < 0) begin
                chk("spurious_mem_request", 64'(mvalid), 64'(0));
            end else begin
                chk("grant_addr", 64'(maddr), 64'(a_snap[win]));
                if (per_chk && last_rise >= 0) chk("cycles_per_grant", 64'(cyc - last_rise), 64'(3));
                last_rise = cyc;
                inflight  = 1;
                in_warp   = win;
                in_addr   = maddr;
                stall     = $urandom_range(smin, smax);
            end
        end else if (inflight && !resp_driven) begin
            chk("stall_valid", 64'(mvalid), 64'(1));
            chk("stall_addr", 64'(maddr), 64'(in_addr));
        end
        if (inflight && !resp_driven) begin
            if (stall == 0) begin
                mready = 1'b1;
                mdata  = instruction_t'($urandom);
                sb.push_back('{in_warp, mdata});
                m_ptr       = (in_warp + 1) % W;
                resp_driven = 1;
            end else begin
                stall--;
            end
            if (chaos && $urandom_range(0, 7) == 0) valid[in_warp] = 1'b0;
            if (chaos) addr[in_warp] = instruction_memory_address_t'($urandom);
        end else if (!inflight && !mvalid && $urandom_range(0, 3) == 0) begin
            mready = 1'b1;
            mdata  = instruction_t'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            if (!pending[i] && mask[i] && $urandom_range(0, 99) < pct) begin
                pending[i] = 1'b1;
                valid[i]   = 1'b1;
                addr[i]    = band_addr(i);
            end
        end
        prev_mvalid = mvalid;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((pending != '0 || inflight) && t < 300) begin
            step('0, 0, 0, 2, 1'b0, 1'b0);
            t++;
        end
        chk("drain_pending", 64'(pending), 64'(0));
        last_rise = -1;
    endtask

    // ---------------- W=4 monitor ----------------
    initial begin
        instruction_t exp_data [W];
        logic         rst_seen;
        exp_t         e;
        rst_seen = 1'b1;
        for (int i = 0; i < W; i++) exp_data[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                for (int i = 0; i < W; i++) exp_data[i] = '0;
                chk("reset_ready", 64'(ready), 64'(0));
                chk("reset_mem_valid", 64'(mvalid), 64'(0));
                chk("reset_mem_addr", 64'(maddr), 64'(0));
            end else if (ready != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'(ready), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("ready_onehot", 64'(ready), 64'(1) << e.warp);
                    exp_data[e.warp] = e.data;
                end
            end
            for (int i = 0; i < W; i++) chk("warp_data", 64'(rdata[i]), 64'(exp_data[i]));
            rst_seen = rst;
        end
    end

    // ---------------- W=1 monitor ----------------
    initial begin
        instruction_t e1;
        forever begin
            @(negedge clk);
            if (!rst1) begin
                chk("w1_no_x", 64'($isunknown({r1, mv1, ma1, d1})), 64'(0));
                if (r1[0]) begin
                    if (sb1.size() == 0) begin
                        chk("w1_unexpected_ready", 64'(r1), 64'(0));
                    end else begin
                        e1 = sb1.pop_front();
                        chk("w1_data", 64'(d1[0]), 64'(e1));
                    end
                end
            end
        end
    end

    // ---------------- W=1 stimulus ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            v1[0] = 1'b1;
            a1[0] = instruction_memory_address_t'(n % 3);
            t = 0;
            while (!mv1 && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("w1_issue", 64'(mv1), 64'(1));
            chk("w1_addr", 64'(ma1), 64'(n % 3));
            a1[0] = 8'hEE;
            @(posedge clk);
            #1;
            mr1 = 1'b1;
            md1 = instruction_t'($urandom);
            sb1.push_back(md1);
            @(posedge clk);
            #1;
            mr1 = 1'b0;
            chk("w1_ready", 64'(r1), 64'(1));
            v1[0] = 1'b0;
        end
        done1 = 1;
    end

    // ---------------- W=4 main sequence ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // single requester (warp 2), two-cycle memory latency
        repeat (12) step(4'b0100, 100, 2, 2, 1'b0, 1'b0);
        drain();
        // all four contending, zero-stall memory
        repeat (30) step(4'b1111, 100, 0, 0, 1'b0, 1'b1);
        drain();
        // only warps 1 and 3
        repeat (30) step(4'b1010, 100, 0, 2, 1'b0, 1'b0);
        drain();
        // long memory stall
        repeat (40) step(4'b1111, 100, 10, 10, 1'b0, 1'b0);
        drain();
        // random traffic with dropped valids and moving addresses
        repeat (500) step(4'b1111, 30, 0, 4, 1'b1, 1'b0);
        drain();

        // reset in the middle of a stalled transaction
        t = 0;
        while (!(inflight && !resp_driven) && t < 50) begin
            step(4'b1111, 100, 20, 20, 1'b0, 1'b0);
            t++;
        end
        chk("reach_busy", 64'(inflight), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = '0;
        pending = '0;
        m_ptr = 0;
        inflight = 0;
        resp_driven = 0;
        prev_mvalid = 1'b0;
        last_rise = -1;
        mready = 1'b1;
        mdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_after_reset", 64'(mvalid), 64'(0));
        end
        repeat (20) step(4'b1111, 100, 0, 1, 1'b0, 1'b0);
        drain();

        t = 0;
        while (!done1 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("w1_done", 64'(done1), 64'(1));
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size() + sb1.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
